fir_datapath: RTL and testbench

FIR_DATAPATH -- requirements
Module: fir_datapath

---
 rtl/fir_datapath.sv | 94 +++++++++
 tb/tb_fir_datapath.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fir_datapath.sv
// FIR execution datapath: 16-entry register file with a copy/load/add/sub/mul ALU.
// It publishes r0 as the filter result when the controller's busy flag falls.
module fir_datapath #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [3:0]        src1,
    input  logic [3:0]        src2,
    input  logic [3:0]        dest,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] fir_coefficient,
    input  logic              modwait,
    output logic              overflow,
    output logic [DATA_W-1:0] fir_out,
    output logic              result_ready,
    output logic              result_err
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LDS   = 3'b010;
    localparam logic [2:0] OP_LDC   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    logic [15:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]       rd1, rd2, sum, diff, wdata;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic                    wr_en, add_ovf, sub_ovf, mul_ovf;
    logic                    modwait_q, acc_dirty, ovf_seen, eos, acc_set;

    assign rd1   = regs[src1];
    assign rd2   = regs[src2];
    assign sum   = rd1 + rd2;
    assign diff  = rd1 - rd2;
    assign a_ext = {{DATA_W{rd1[DATA_W-1]}}, rd1};
    assign b_ext = {{DATA_W{rd2[DATA_W-1]}}, rd2};
    assign prod  = a_ext * b_ext;

    assign add_ovf = (rd1[DATA_W-1] == rd2[DATA_W-1]) && (sum[DATA_W-1] != rd1[DATA_W-1]);
    assign sub_ovf = (rd1[DATA_W-1] != rd2[DATA_W-1]) && (diff[DATA_W-1] != rd1[DATA_W-1]);
    // Product fits iff the top DATA_W+1 bits are a pure sign extension.
    assign mul_ovf = (prod[2*DATA_W-1:DATA_W-1] != '0) && (prod[2*DATA_W-1:DATA_W-1] != '1);

    always_comb begin
        wr_en    = 1'b0;
        wdata    = '0;
        overflow = 1'b0;
        case (op)
            OP_COPY: begin wr_en = 1'b1; wdata = rd1;             end
            OP_LDS:  begin wr_en = 1'b1; wdata = sample_data;     end
            OP_LDC:  begin wr_en = 1'b1; wdata = fir_coefficient; end
            OP_ADD:  begin wr_en = 1'b1; wdata = sum;  overflow = add_ovf; end
            OP_SUB:  begin wr_en = 1'b1; wdata = diff; overflow = sub_ovf; end
            OP_MUL:  begin wr_en = 1'b1; wdata = prod[DATA_W-1:0]; overflow = mul_ovf; end
            default: ;
        endcase
    end

    assign eos     = modwait_q & ~modwait;
    assign acc_set = ((op == OP_ADD) || (op == OP_SUB)) && (dest == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[dest] <= wdata;
        end
    end

    // Flags use their pre-edge values at end-of-sequence; a same-cycle set survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modwait_q    <= 1'b0;
            acc_dirty    <= 1'b0;
            ovf_seen     <= 1'b0;
            fir_out      <= '0;
            result_ready <= 1'b0;
            result_err   <= 1'b0;
        end else begin
            modwait_q    <= modwait;
            acc_dirty    <= acc_set | (acc_dirty & ~eos);
            ovf_seen     <= overflow | (ovf_seen & ~eos);
            result_ready <= eos & acc_dirty & ~ovf_seen;
            result_err   <= eos & acc_dirty & ovf_seen;
            if (eos && acc_dirty && !ovf_seen)
                fir_out <= regs[0];
        end
    end

endmodule

// File: tb/tb_fir_datapath.sv
// Directed bench for fir_datapath: expected result pulses go into a scoreboard
// queue and an independent monitor pops and compares them.
module tb_fir_datapath;

    localparam logic [2:0] NOP = 3'd0, CPY = 3'd1, LDS = 3'd2, LDC = 3'd3,
                           ADD = 3'd4, SUB = 3'd5, MUL = 3'd6, RSV = 3'd7;

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  op = '0;
    logic [3:0]  src1 = '0, src2 = '0, dest = '0;
    logic [15:0] sample_data = '0, fir_coefficient = '0;
    logic        modwait = 1'b0;
    logic        overflow, result_ready, result_err;
    logic [15:0] fir_out;

    typedef struct packed { logic err; logic [15:0] val; } exp_t;
    exp_t        sb[$];
    int          errors = 0, checks = 0;
    logic [15:0] exp_fir = '0;

    fir_datapath #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .op(op), .src1(src1), .src2(src2), .dest(dest),
        .sample_data(sample_data), .fir_coefficient(fir_coefficient),
        .modwait(modwait), .overflow(overflow), .fir_out(fir_out),
        .result_ready(result_ready), .result_err(result_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (result_ready || result_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: ready=%b err=%b fir_out=%h", result_ready, result_err, fir_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({result_err, result_ready, fir_out} !== {e.err, ~e.err, e.val}) begin
                    errors++;
                    $display("FAIL result_pulse: got err=%b ready=%b fir_out=%h expected err=%b ready=%b fir_out=%h",
                             result_err, result_ready, fir_out, e.err, ~e.err, e.val);
                end
            end
        end
    end

    task automatic cmd(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic mw, input logic eovf,
                       input logic [15:0] dat = 16'h0);
        @(negedge clk);
        op = o; src1 = a; src2 = b; dest = d; modwait = mw;
        sample_data     = (o == LDC) ? ~dat : dat;
        fir_coefficient = (o == LDC) ? dat : ~dat;
        #1 chk($sformatf("overflow op=%0d s1=%0d s2=%0d", o, a, b), overflow, eovf);
    endtask

    task automatic quiet();
        @(negedge clk);
        op = NOP; modwait = 1'b0;
        #1 chk("no_pulse", {result_ready, result_err}, 2'b00);
    endtask

    // Readout through the result path: r0 = rX - r15 (r15 stays 0), then end the sequence.
    task automatic rd(input logic [3:0] idx, input logic [15:0] exp);
        cmd(SUB, idx, 4'd15, 4'd0, 1'b1, 1'b0);
        cmd(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        sb.push_back('{err: 1'b0, val: exp});
        exp_fir = exp;
    endtask

    initial begin
        #12;
        chk("reset_fir_out", fir_out, 16'h0);
        chk("reset_pulses", {result_ready, result_err}, 2'b00);
        chk("reset_overflow", overflow, 1'b0);
        @(negedge clk) rst = 1'b0;

        // Coefficient-load sequence: no pulse at its end
        for (int i = 0; i < 4; i++) cmd(LDC, 0, 0, 4'(6 + i), 1'b1, 1'b0, 16'(i + 1));
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        quiet();

        // 4-tap FIR: 10*1 - 20*2 + 30*3 - 40*4 = -100
        for (int i = 0; i < 4; i++) cmd(LDS, 0, 0, 4'(1 + i), 1'b1, 1'b0, 16'(10 * (i + 1)));
        cmd(SUB, 0, 0, 0, 1'b1, 1'b0);
        cmd(MUL, 1, 6, 10, 1'b1, 1'b0); cmd(ADD, 0, 10, 0, 1'b1, 1'b0);
        cmd(MUL, 2, 7, 10, 1'b1, 1'b0); cmd(SUB, 0, 10, 0, 1'b1, 1'b0);
        cmd(MUL, 3, 8, 10, 1'b1, 1'b0); cmd(ADD, 0, 10, 0, 1'b1, 1'b0);
        cmd(MUL, 4, 9, 10, 1'b1, 1'b0); cmd(SUB, 0, 10, 0, 1'b1, 1'b0);
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        sb.push_back('{err: 1'b0, val: 16'hFF9C}); exp_fir = 16'hFF9C;

        // COPY r5->r5; SUB to r0 in the end-of-sequence cycle keeps acc_dirty set
        cmd(LDS, 0, 0, 5, 1'b1, 1'b0, 16'h1234);
        cmd(CPY, 5, 0, 5, 1'b1, 1'b0);
        cmd(SUB, 5, 15, 0, 1'b0, 1'b0);
        quiet();
        cmd(NOP, 0, 0, 0, 1'b1, 1'b0);
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        sb.push_back('{err: 1'b0, val: 16'h1234}); exp_fir = 16'h1234;

        // SUB with src1 = dest, then reserved op must not touch r11
        cmd(LDS, 0, 0, 11, 1'b1, 1'b0, 16'd100);
        cmd(SUB, 11, 1, 11, 1'b1, 1'b0);
        cmd(RSV, 1, 1, 11, 1'b1, 1'b0);
        rd(11, 16'd90);

        // ADD/SUB overflow boundaries, no r0 write -> no pulse
        cmd(LDS, 0, 0, 1, 1'b1, 1'b0, 16'h7FFF);
        cmd(LDS, 0, 0, 2, 1'b1, 1'b0, 16'h0001);
        cmd(ADD, 1, 2, 3, 1'b1, 1'b1);
        cmd(SUB, 3, 2, 12, 1'b1, 1'b1);
        cmd(RSV, 1, 2, 4, 1'b1, 1'b0);
        cmd(ADD, 1, 15, 13, 1'b1, 1'b0);
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        quiet();
        rd(3, 16'h8000);
        rd(12, 16'h7FFF);
        rd(4, 16'd40);
        // Overflowing accumulate into r0 -> error pulse, fir_out held
        cmd(ADD, 1, 2, 0, 1'b1, 1'b1);
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        sb.push_back('{err: 1'b1, val: exp_fir});

        // MUL range checks
        cmd(LDS, 0, 0, 1, 1'b1, 1'b0, 16'd300);
        cmd(LDS, 0, 0, 2, 1'b1, 1'b0, 16'd200);
        cmd(MUL, 1, 2, 3, 1'b1, 1'b1);
        cmd(LDS, 0, 0, 4, 1'b1, 1'b0, 16'hFFFD);
        cmd(LDS, 0, 0, 5, 1'b1, 1'b0, 16'd4);
        cmd(MUL, 4, 5, 6, 1'b1, 1'b0);
        cmd(LDS, 0, 0, 7, 1'b1, 1'b0, 16'h8000);
        cmd(LDS, 0, 0, 8, 1'b1, 1'b0, 16'hFFFF);
        cmd(MUL, 7, 8, 9, 1'b1, 1'b1);
        cmd(LDS, 0, 0, 10, 1'b1, 1'b0, 16'd1);
        cmd(MUL, 7, 10, 10, 1'b1, 1'b0);
        cmd(NOP, 0, 0, 0, 1'b0, 1'b0);
        quiet();
        rd(3, 16'hEA60);
        rd(9, 16'h8000);
        rd(10, 16'h8000);
        rd(6, 16'hFFF4);

        // Asynchronous reset in the middle of a sequence
        cmd(LDS, 0, 0, 1, 1'b1, 1'b0, 16'd5);
        cmd(SUB, 0, 0, 0, 1'b1, 1'b0);
        cmd(MUL, 1, 1, 10, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_fir = 16'h0;
        chk("async_rst_fir_out", fir_out, 16'h0);
        chk("async_rst_pulses", {result_ready, result_err}, 2'b00);
        chk("async_rst_overflow", overflow, 1'b0);
        @(negedge clk);
        @(negedge clk) begin op = NOP; modwait = 1'b0; rst = 1'b0; end
        quiet();
        quiet();
        rd(1, 16'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_fir_out", fir_out, exp_fir);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
